// File: rtl/telemetry_framer.sv
// Serialises a snapshot of NUM_CH sensor samples into a byte frame
// (A5, SEQ, MASK, samples MSB-first, XOR checksum) for a UART transmitter.
module telemetry_framer #(
   parameter int NUM_CH      = 2,
   parameter int DATA_W      = 16,
   parameter int PERIOD_CLKS = 12000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     auto_en,
   input  logic                     trig_in,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [7:0]               byte_data,
   output logic                     byte_valid,
   input  logic                     byte_ready,
   output logic                     busy,
   output logic                     overrun
);
   localparam int TOT_W  = NUM_CH * DATA_W;
   localparam int NBYTES = TOT_W / 8;
   localparam int CNT_W  = $clog2(PERIOD_CLKS);
   localparam int IDX_W  = 6;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_SEQ  = 3'd2;
   localparam logic [2:0] S_MASK = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_CSUM = 3'd5;

   // Reorders the samples so channel 0's MSB byte sits at the top of the shifter.
   function automatic logic [TOT_W-1:0] order_samples(input logic [TOT_W-1:0] d);
      logic [TOT_W-1:0] o;
      o = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         o[TOT_W-(k+1)*DATA_W +: DATA_W] = d[k*DATA_W +: DATA_W];
      end
      return o;
   endfunction

   logic [2:0]       state_r, state_s;
   logic [7:0]       seq_r, seq_s;
   logic [7:0]       mask_r, mask_s;
   logic [7:0]       csum_r, csum_s;
   logic [7:0]       byte_data_r, byte_data_s;
   logic [TOT_W-1:0] shreg_r, shreg_s;
   logic [IDX_W-1:0] idx_r, idx_s;
   logic [CNT_W-1:0] cnt_r;
   logic             byte_valid_r, busy_r, overrun_r;
   logic             tick_s, trigger_s, accept_s;

   assign tick_s    = ena && auto_en && (cnt_r == CNT_W'(PERIOD_CLKS - 1));
   assign trigger_s = ena && (trig_in || tick_s);
   assign accept_s  = (state_r != S_IDLE) && byte_ready;

   // Period counter: free-runs only while both enables are high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (ena && auto_en) begin
         cnt_r <= tick_s ? '0 : cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Frame sequencer: next state and the byte to present after each handshake.
   always_comb begin
      state_s     = state_r;
      seq_s       = seq_r;
      mask_s      = mask_r;
      csum_s      = csum_r;
      byte_data_s = byte_data_r;
      shreg_s     = shreg_r;
      idx_s       = idx_r;
      case (state_r)
         S_IDLE: begin
            if (trigger_s) begin
               state_s     = S_HDR;
               byte_data_s = 8'hA5;
               csum_s      = 8'h00;
               shreg_s     = order_samples(ch_data);
               mask_s      = 8'(ch_valid);
               idx_s       = '0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_HDR: begin
            if (accept_s) begin
               state_s     = S_SEQ;
               byte_data_s = seq_r;
               csum_s      = csum_r ^ byte_data_r;
            end else begin
               state_s = S_HDR;
            end
         end
         S_SEQ: begin
            if (accept_s) begin
               state_s     = S_MASK;
               byte_data_s = mask_r;
               csum_s      = csum_r ^ byte_data_r;
            end else begin
               state_s = S_SEQ;
            end
         end
         S_MASK: begin
            if (accept_s) begin
               state_s     = S_DATA;
               byte_data_s = shreg_r[TOT_W-1 -: 8];
               shreg_s     = shreg_r << 8;
               idx_s       = '0;
               csum_s      = csum_r ^ byte_data_r;
            end else begin
               state_s = S_MASK;
            end
         end
         S_DATA: begin
            if (accept_s && (idx_r == IDX_W'(NBYTES - 1))) begin
               // Checksum folds in the data byte being accepted right now.
               state_s     = S_CSUM;
               byte_data_s = csum_r ^ byte_data_r;
               csum_s      = csum_r ^ byte_data_r;
            end else if (accept_s) begin
               byte_data_s = shreg_r[TOT_W-1 -: 8];
               shreg_s     = shreg_r << 8;
               idx_s       = idx_r + IDX_W'(1);
               csum_s      = csum_r ^ byte_data_r;
            end else begin
               state_s = S_DATA;
            end
         end
         S_CSUM: begin
            if (accept_s) begin
               state_s     = S_IDLE;
               byte_data_s = 8'h00;
               seq_s       = seq_r + 8'd1;
            end else begin
               state_s = S_CSUM;
            end
         end
         default: begin
            state_s     = S_IDLE;
            byte_data_s = 8'h00;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         seq_r        <= 8'h00;
         mask_r       <= 8'h00;
         csum_r       <= 8'h00;
         byte_data_r  <= 8'h00;
         shreg_r      <= '0;
         idx_r        <= '0;
         byte_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         seq_r        <= seq_s;
         mask_r       <= mask_s;
         csum_r       <= csum_s;
         byte_data_r  <= byte_data_s;
         shreg_r      <= shreg_s;
         idx_r        <= idx_s;
         byte_valid_r <= (state_s != S_IDLE);
         busy_r       <= (state_s != S_IDLE);
         overrun_r    <= trigger_s && (state_r != S_IDLE);
      end
   end

   assign byte_data  = byte_data_r;
   assign byte_valid = byte_valid_r;
   assign busy       = busy_r;
   assign overrun    = overrun_r;
endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: NUM_CH=2, DATA_W=16, PERIOD_CLKS=10,
// expected frames hand-computed.
module tb_telemetry_framer;
   logic        clk = 1'b0;
   logic        rst_n, ena, auto_en, trig_in, byte_ready;
   logic [31:0] ch_data;
   logic [1:0]  ch_valid;
   logic [7:0]  byte_data;
   logic        byte_valid, busy, overrun;
   int          n_cmp = 0;
   int          n_bad = 0;

   telemetry_framer #(.NUM_CH(2), .DATA_W(16), .PERIOD_CLKS(10)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .auto_en(auto_en), .trig_in(trig_in),
      .ch_data(ch_data), .ch_valid(ch_valid), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_trig();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Collects one 8-byte frame; stall cycles of byte_ready=0 before each accept,
   // optional trig_in pulse on the cycle that accepts byte number trig_byte.
   task automatic get_frame(input int stall, input int trig_byte, output logic [7:0] fb [8],
                            output int got, output int unstable, output int ovr_hits);
      got = 0; unstable = 0; ovr_hits = 0;
      for (int i = 0; i < 8; i++) fb[i] = 8'h00;
      for (int b = 0; b < 8; b++) begin
         int w;
         w = 0;
         while (byte_valid !== 1'b1 && w < 40) begin
            step();
            w++;
            if (overrun === 1'b1) ovr_hits++;
         end
         if (byte_valid !== 1'b1) return;
         fb[b] = byte_data;
         got++;
         for (int s = 0; s < stall; s++) begin
            byte_ready = 1'b0;
            step();
            if (overrun === 1'b1) ovr_hits++;
            if (byte_valid !== 1'b1 || byte_data !== fb[b]) unstable++;
         end
         byte_ready = 1'b1;
         if (b == trig_byte) trig_in = 1'b1;
         step();
         trig_in = 1'b0;
         if (overrun === 1'b1) ovr_hits++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; auto_en = 1'b0; trig_in = 1'b0; byte_ready = 1'b1;
      ch_data = {16'hABCD, 16'h1234}; ch_valid = 2'b11;
      #3;
      n_cmp++;
      if ({byte_valid, busy, overrun, byte_data} !== 11'h000) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 000", {byte_valid, busy, overrun, byte_data});
      end
      step();
      rst_n = 1'b1;
      step();
      step();
      n_cmp++;
      if ({byte_valid, busy, overrun, byte_data} !== 11'h000) begin
         n_bad++; $display("FAIL idle_after_reset: got %h want 000", {byte_valid, busy, overrun, byte_data});
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp [8] = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE6};
      logic [7:0] fb [8];
      int got, uns, ovr;
      pulse_trig();
      n_cmp++;
      if (byte_valid !== 1'b1 || byte_data !== 8'hA5 || busy !== 1'b1) begin
         n_bad++; $display("FAIL basic_latency: valid=%b data=%h busy=%b want 1 a5 1", byte_valid, byte_data, busy);
      end
      get_frame(0, -1, fb, got, uns, ovr);
      n_cmp++;
      if (got !== 8) begin n_bad++; $display("FAIL basic_count: got %0d bytes want 8", got); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (fb[i] !== exp[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %h want %h", i, fb[i], exp[i]); end
      end
      n_cmp++;
      if (busy !== 1'b0 || byte_valid !== 1'b0) begin
         n_bad++; $display("FAIL basic_idle: busy=%b valid=%b want 0 0", busy, byte_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp [8] = '{8'hA5, 8'h01, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE7};
      logic [7:0] fb [8];
      int got, uns, ovr;
      pulse_trig();
      ch_data = 32'h5555_AAAA;
      ch_valid = 2'b00;
      get_frame(3, -1, fb, got, uns, ovr);
      n_cmp++;
      if (got !== 8) begin n_bad++; $display("FAIL bp_count: got %0d bytes want 8", got); end
      n_cmp++;
      if (uns !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", uns); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (fb[i] !== exp[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %h want %h", i, fb[i], exp[i]); end
      end
      ch_data = {16'hABCD, 16'h1234};
      ch_valid = 2'b11;
   endtask

   task automatic test_overrun();
      logic [7:0] exp [8] = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0};
      logic [7:0] fb [8];
      int got, uns, ovr;
      apply_reset();
      ch_data = {16'h0304, 16'h0102};
      ch_valid = 2'b01;
      pulse_trig();
      get_frame(0, 2, fb, got, uns, ovr);
      n_cmp++;
      if (ovr !== 1) begin n_bad++; $display("FAIL ovr_pulse: got %0d overrun cycles want 1", ovr); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (fb[i] !== exp[i]) begin n_bad++; $display("FAIL ovr_byte%0d: got %h want %h", i, fb[i], exp[i]); end
      end
      repeat (3) step();
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL ovr_single_frame: busy=%b want 0", busy); end
      pulse_trig();
      get_frame(0, -1, fb, got, uns, ovr);
      n_cmp++;
      if (fb[1] !== 8'h01 || fb[7] !== 8'hA1) begin
         n_bad++; $display("FAIL ovr_next_seq: seq=%h csum=%h want 01 a1", fb[1], fb[7]);
      end
      ch_data = {16'hABCD, 16'h1234};
      ch_valid = 2'b11;
   endtask

   task automatic test_auto();
      int n;
      auto_en = 1'b1;
      n = 0;
      while (byte_valid !== 1'b1 && n < 40) begin step(); n++; end
      n_cmp++;
      if (n !== 10 || byte_data !== 8'hA5) begin
         n_bad++; $display("FAIL auto_first: got %0d cycles data %h want 10 a5", n, byte_data);
      end
      n = 0;
      while (byte_valid === 1'b1 && n < 40) begin step(); n++; end
      while (byte_valid !== 1'b1 && n < 40) begin step(); n++; end
      n_cmp++;
      if (n !== 10) begin n_bad++; $display("FAIL auto_period: got %0d cycles want 10", n); end
      step();
      n_cmp++;
      if (byte_data !== 8'h03) begin n_bad++; $display("FAIL auto_seq: got %h want 03", byte_data); end
      repeat (8) step();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      n_cmp++;
      if (byte_valid !== 1'b1 || byte_data !== 8'hA5) begin
         n_bad++; $display("FAIL auto_coincident_start: valid=%b data=%h want 1 a5", byte_valid, byte_data);
      end
      step();
      n_cmp++;
      if (overrun !== 1'b0 || byte_data !== 8'h04) begin
         n_bad++; $display("FAIL auto_coincident_one: overrun=%b seq=%h want 0 04", overrun, byte_data);
      end
      step();
      step();
      ena = 1'b0;
      repeat (20) step();
      n_cmp++;
      if (busy !== 1'b0 || byte_valid !== 1'b0) begin
         n_bad++; $display("FAIL ena_low_finish: busy=%b valid=%b want 0 0", busy, byte_valid);
      end
      ena = 1'b1;
      n = 0;
      while (byte_valid !== 1'b1 && n < 40) begin step(); n++; end
      n_cmp++;
      if (n !== 7) begin n_bad++; $display("FAIL ena_hold_count: got %0d cycles want 7", n); end
      auto_en = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin step(); n++; end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL auto_drain: busy=%b want 0", busy); end
   endtask

   task automatic test_wrap_reset();
      logic [7:0] fb [8];
      int got, uns, ovr;
      apply_reset();
      for (int i = 0; i < 257; i++) begin
         pulse_trig();
         get_frame(0, -1, fb, got, uns, ovr);
         n_cmp++;
         if (fb[1] !== 8'(i) || fb[7] !== (8'hE6 ^ 8'(i))) begin
            n_bad++; $display("FAIL wrap_frame%0d: seq=%h csum=%h want %h %h", i, fb[1], fb[7], 8'(i), 8'hE6 ^ 8'(i));
         end
      end
      pulse_trig();
      step();
      step();
      step();
      n_cmp++;
      if (byte_data !== 8'h12 || byte_valid !== 1'b1) begin
         n_bad++; $display("FAIL rst_in_data_setup: data=%h valid=%b want 12 1", byte_data, byte_valid);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (byte_valid !== 1'b0 || byte_data !== 8'h00 || busy !== 1'b0) begin
         n_bad++; $display("FAIL rst_async: valid=%b data=%h busy=%b want 0 00 0", byte_valid, byte_data, busy);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      n_cmp++;
      if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL rst_abandon: valid=%b want 0", byte_valid); end
      pulse_trig();
      get_frame(0, -1, fb, got, uns, ovr);
      n_cmp++;
      if (got !== 8 || fb[1] !== 8'h00 || fb[7] !== 8'hE6) begin
         n_bad++; $display("FAIL rst_seq0: got %0d seq=%h csum=%h want 8 00 e6", got, fb[1], fb[7]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overrun();
      test_auto();
      test_wrap_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/telemetry_framer.md
TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2; number of sensor channels, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 16; bits per channel sample, a multiple of 8, legal range 8..32.
REQ-003 SHALL have parameter PERIOD_CLKS, default 12000000; auto-trigger period in clk cycles, legal minimum 2.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  in  1  global enable.
REQ-007 SHALL have port auto_en  in  1  enables the periodic trigger.
REQ-008 SHALL have port trig_in  in  1  manual frame request, sampled each cycle.
REQ-009 SHALL have port ch_data  in  NUM_CH*DATA_W  channel samples; channel k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port ch_valid  in  NUM_CH  per-channel sample-valid flags.
REQ-011 SHALL have port byte_data  out  8  frame byte to the UART transmitter.
REQ-012 SHALL have port byte_valid  out  1  byte_data is valid.
REQ-013 SHALL have port byte_ready  in  1  transmitter accepts byte_data.
REQ-014 SHALL have port busy  out  1  a frame is in progress.
REQ-015 SHALL have port overrun  out  1  one-cycle pulse; a trigger was dropped.

Function
REQ-016 SHALL emit each frame in this byte order: 0xA5, SEQ, MASK, channel 0..NUM_CH-1 samples each MSB byte first, CSUM; frame length 4+NUM_CH*DATA_W/8 bytes.
REQ-017 SHALL form MASK as {zeros, ch_valid}, zero-extended to 8 bits.
REQ-018 SHALL form CSUM as the XOR of all preceding bytes of the frame, header included.
REQ-019 SHALL reset SEQ to 0, increment it by 1 when the CSUM byte is accepted, and wrap it from 255 to 0.
REQ-020 SHALL count the period counter 0..PERIOD_CLKS-1 while ena&&auto_en; assert the auto tick when the count equals PERIOD_CLKS-1, then wrap to 0; hold the count when ena or auto_en is low.
REQ-021 SHALL define trigger as ena && (trig_in || auto tick); simultaneous trig_in and auto tick SHALL produce exactly one frame.
REQ-022 SHALL, on a trigger in IDLE, snapshot ch_data and ch_valid in that cycle; later input changes SHALL NOT affect the frame.
REQ-023 SHALL implement the FSM IDLE -> HDR -> SEQ -> MASK -> DATA -> CSUM -> IDLE; DATA iterates over all NUM_CH*DATA_W/8 bytes using a byte index.
REQ-024 SHALL leave each non-IDLE state only on byte_valid && byte_ready.
REQ-025 SHALL, for a trigger at cycle T, assert byte_valid=1 and byte_data=0xA5 at T+1.
REQ-026 SHALL keep byte_valid high in every non-IDLE state and low in IDLE.
REQ-027 SHALL hold byte_data stable while byte_valid && !byte_ready.
REQ-028 SHALL drive busy = (state != IDLE).
REQ-029 SHALL return to IDLE in the cycle after CSUM is accepted; a trigger in that IDLE cycle SHALL be accepted.
REQ-030 SHALL, on a trigger while busy, drop it, pulse overrun for one cycle and leave the current frame unchanged.
REQ-031 SHALL, when ena is deasserted mid-frame, still complete the current frame; no new trigger is accepted while ena is low.

Reset
REQ-032 SHALL, on rst_n=0, immediately force state IDLE, byte_valid=0, byte_data=0x00, busy=0, overrun=0, SEQ=0, period counter=0 and byte index=0.
REQ-033 SHALL abandon any in-progress frame on reset without emitting further bytes; the first frame after reset SHALL carry SEQ=0x00.

Verification
REQ-034 Basic frame: NUM_CH=2, DATA_W=16, ch_data ch0=0x1234, ch1=0xABCD, ch_valid=2'b11, byte_ready=1, one-cycle trig_in -> bytes A5 00 03 12 34 AB CD E6, then busy=0.
REQ-035 Backpressure: same frame with byte_ready low 3 cycles on each byte -> identical byte sequence; byte_data stable during every stall; ch_data changed mid-frame has no effect.
REQ-036 Overrun: trig_in pulsed during the MASK byte -> overrun pulses 1 cycle; exactly one frame emitted; next trigger yields SEQ=0x01.
REQ-037 Auto mode: PERIOD_CLKS=10, auto_en=1, byte_ready=1 -> frame starts every 10 cycles; auto tick coincident with trig_in yields one frame; ena=0 holds the counter.
REQ-038 SEQ wrap and reset: 256 frames -> SEQ 0xFF followed by 0x00; rst_n asserted during the DATA state -> byte_valid=0 at once; next frame after reset shows SEQ=0x00.
